fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined core; replaces the bare PC register and PC-select muxing of the IF stage. It holds the fetch PC, runs the busywait read handshake to instruction memory, and buffers fetched {PC, instruction} pairs in a FETCH_QUEUE_DEPTH FIFO that feeds the IF/ID register. Branch/jump redirects from EX flush the FIFO, and any in-flight memory response is discarded.

Parameters:
XLEN, 32, width of PC, address and instruction word
FETCH_QUEUE_DEPTH, 4, entries in fetch FIFO; power of two, minimum 2
RESET_VECTOR, 32'h0000_0000, PC loaded on reset

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
INSTR_MEM_READ  output  1  read request to instruction memory
INSTR_MEM_ADDR  output  XLEN  read address; word aligned
INSTR_MEM_READ_DATA  input  XLEN  returned instruction word
INSTR_MEM_BUSYWAIT  input  1  memory busy; transfer completes at an edge with READ=1, BUSYWAIT=0
REDIRECT  input  1  branch/jump taken in EX (BJ signal)
REDIRECT_TARGET  input  XLEN  new fetch PC; bits [1:0] ignored, treated as 00
ID_HOLD  input  1  decode stall (load-use hazard or data-memory busywait); head entry not consumed
ID_VALID  output  1  FIFO head valid
ID_PC  output  XLEN  PC of head entry
ID_INSTRUCTION  output  XLEN  instruction of head entry

Behaviour:
- Reset (async, active-high): fetch PC = RESET_VECTOR, FIFO empty, state FETCH, no transfer outstanding. ID_VALID=0, ID_PC=0, ID_INSTRUCTION=0, INSTR_MEM_READ=0 while RESET is high.
- States:
  - FETCH: INSTR_MEM_READ=1 when occupancy + outstanding < FETCH_QUEUE_DEPTH, else 0 (idle).
  - DISCARD: INSTR_MEM_READ=1 at the old address until completion; the returned data is dropped.
- Address stability: INSTR_MEM_ADDR changes only at the completion edge or while READ=0. It never changes while READ=1 and BUSYWAIT=1.
- Completion in FETCH (no redirect): push {fetch PC, READ_DATA}; fetch PC += 4, mod 2^XLEN (wraps to 0). With zero-wait memory READ stays high, giving 1 instruction/cycle.
- Pop: at an edge with ID_VALID=1 and ID_HOLD=0. ID_PC and ID_INSTRUCTION are driven combinationally from the head. An empty FIFO drives ID_VALID=0, and ID_PC/ID_INSTRUCTION keep their last values.
- Latency: a push at edge N makes the entry visible at ID_* in cycle N+1. No combinational path from memory data to ID_*.
- Push and pop in the same edge: both take effect and occupancy is unchanged. Overflow is impossible by the reservation rule; underflow is impossible because pop requires ID_VALID.
- REDIRECT=1 at an edge (highest priority):
  - FIFO cleared; any pop or push at that edge is ignored.
  - fetch PC = {REDIRECT_TARGET[XLEN-1:2], 2'b00}.
  - If a transfer is outstanding and not completing at this edge, go to DISCARD; otherwise go to FETCH.
  - ID_VALID=0 in the next cycle.
- REDIRECT during DISCARD: update fetch PC to the new target and stay in DISCARD.
- DISCARD completion: data dropped, go to FETCH, and issue the target request the next cycle.
- ID_HOLD together with REDIRECT: the redirect wins.
- RESET mid-transfer: state cleared immediately. The memory model is reset by the same RESET.

Optional Feature:
FETCH_PERF_CNT_EN. When defined, adds three output ports, each 32 bits, saturating at all-ones, cleared on RESET:
- PERF_FETCHED: +1 per push.
- PERF_DISCARDED: +1 per dropped DISCARD completion, plus +N per redirect that flushes N valid entries.
- PERF_STARVED: +1 per cycle with ID_VALID=0 and RESET low.
When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory returning word = address, ID_HOLD=0 -> ID_VALID rises in the 2nd cycle; ID_PC sequence 0,4,8,12 on consecutive cycles; ID_INSTRUCTION equals ID_PC.
- ID_HOLD=1 held for 10 cycles, DEPTH=4 -> exactly 4 pushes, then INSTR_MEM_READ=0. On release, entries 0,4,8,12 emerge in order with no loss or duplication.
- BUSYWAIT held 3 cycles on address 8, REDIRECT to 0x100 in the 2nd busy cycle -> INSTR_MEM_ADDR stays 8 until completion, word at 8 never appears at ID, next request is 0x100, and the first valid ID_PC is 0x100.
- REDIRECT to 0x203 while FIFO holds 3 entries and ID_HOLD=1 -> next cycle ID_VALID=0 and fetch address is 0x200; with FETCH_PERF_CNT_EN, PERF_DISCARDED increases by 3.
- RESET_VECTOR=32'hFFFF_FFF8, free-running fetch -> ID_PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- RESET asserted asynchronously mid-cycle during a busy transfer with a full FIFO -> ID_VALID and INSTR_MEM_READ drop without waiting for a clock edge; after release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, busywait read handshake and a {PC, instruction} FIFO feeding ID.
// Optional performance counters are built when the FETCH_PERF_CNT_EN macro is defined.
module fetch_unit #(
    parameter int              XLEN              = 32,
    parameter int              FETCH_QUEUE_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR      = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic            INSTR_MEM_READ,
    output logic [XLEN-1:0] INSTR_MEM_ADDR,
    input  logic [XLEN-1:0] INSTR_MEM_READ_DATA,
    input  logic            INSTR_MEM_BUSYWAIT,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_TARGET,
    input  logic            ID_HOLD,
    output logic            ID_VALID,
    output logic [XLEN-1:0] ID_PC,
    output logic [XLEN-1:0] ID_INSTRUCTION
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     PERF_FETCHED,
    output logic [31:0]     PERF_DISCARDED,
    output logic [31:0]     PERF_STARVED
`endif
);

    localparam int PTR_W = $clog2(FETCH_QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FETCH_QUEUE_DEPTH);

    typedef enum logic {
        ST_FETCH,
        ST_DISCARD
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    state_t          state, state_next;
    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic [XLEN-1:0] discard_addr, discard_addr_next;
    logic [XLEN-1:0] last_pc, last_instr;

    entry_t          queue_mem [FETCH_QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;

    logic            mem_read;
    logic            complete;
    logic            push;
    logic            pop;
    logic            id_valid;
    logic [XLEN-1:0] target_aligned;
    logic            target_unused;

    assign target_aligned = {REDIRECT_TARGET[XLEN-1:2], 2'b00};
    assign target_unused  = ^REDIRECT_TARGET[1:0];

    // A request is only started when the FIFO has room, so the slot is reserved for its data.
    assign id_valid = (count != '0);
    assign mem_read = !RESET && ((state == ST_DISCARD) || (count < DEPTH_CNT));
    assign complete = mem_read && !INSTR_MEM_BUSYWAIT;
    assign push     = (state == ST_FETCH) && complete && !REDIRECT;
    assign pop      = id_valid && !ID_HOLD && !REDIRECT;

    assign INSTR_MEM_READ = mem_read;
    // The address is held at the abandoned request until memory finishes it.
    assign INSTR_MEM_ADDR = (state == ST_DISCARD) ? discard_addr : fetch_pc;

    assign ID_VALID       = id_valid;
    assign ID_PC          = id_valid ? queue_mem[rd_ptr].pc    : last_pc;
    assign ID_INSTRUCTION = id_valid ? queue_mem[rd_ptr].instr : last_instr;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next        = state;
        fetch_pc_next     = fetch_pc;
        discard_addr_next = discard_addr;
        case (state)
            ST_FETCH: begin
                if (REDIRECT && mem_read && INSTR_MEM_BUSYWAIT) begin
                    state_next        = ST_DISCARD;
                    discard_addr_next = fetch_pc;
                end
            end
            ST_DISCARD: begin
                if (complete) begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase
        if (REDIRECT) begin
            fetch_pc_next = target_aligned;
        end else if (push) begin
            fetch_pc_next = fetch_pc + XLEN'(4);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= ST_FETCH;
            fetch_pc     <= RESET_VECTOR;
            discard_addr <= RESET_VECTOR;
        end else begin
            state        <= state_next;
            fetch_pc     <= fetch_pc_next;
            discard_addr <= discard_addr_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_pc    <= '0;
            last_instr <= '0;
        end else if (REDIRECT) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                last_pc    <= queue_mem[rd_ptr].pc;
                last_instr <= queue_mem[rd_ptr].instr;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only read when count marks them valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            queue_mem[wr_ptr] <= '{pc: fetch_pc, instr: INSTR_MEM_READ_DATA};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [31:0] discard_inc;

    always_comb begin
        discard_inc = '0;
        if ((state == ST_DISCARD) && complete) begin
            discard_inc = 32'd1;
        end
        if (REDIRECT) begin
            discard_inc = discard_inc + 32'(count);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PERF_FETCHED   <= '0;
            PERF_DISCARDED <= '0;
            PERF_STARVED   <= '0;
        end else begin
            if (push) begin
                PERF_FETCHED <= sat_add(PERF_FETCHED, 32'd1);
            end
            PERF_DISCARDED <= sat_add(PERF_DISCARDED, discard_inc);
            if (!id_valid) begin
                PERF_STARVED <= sat_add(PERF_STARVED, 32'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: stimulus table, directed corner sequences and a random run
// against a queue-based reference model. Perf counters are checked when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        mem_read, id_valid, id_hold, busy, redirect;
    logic [31:0] mem_addr, mem_data, id_pc, id_instr, target;
    logic        mem_read2, id_valid2;
    logic [31:0] mem_addr2, mem_data2, id_pc2, id_instr2;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'h0;
    logic [31:0] xor_key = 32'h0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_discarded, perf_starved;
    logic [31:0] perf_fetched2, perf_discarded2, perf_starved2;
`endif

    always #5 CLK = ~CLK;

    // Memory models: the returned word is derived from the address.
    assign mem_data  = mem_addr ^ xor_key;
    assign mem_data2 = mem_addr2;

    fetch_unit #(.XLEN(XLEN), .FETCH_QUEUE_DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
        .CLK(CLK), .RESET(RESET),
        .INSTR_MEM_READ(mem_read), .INSTR_MEM_ADDR(mem_addr),
        .INSTR_MEM_READ_DATA(mem_data), .INSTR_MEM_BUSYWAIT(busy),
        .REDIRECT(redirect), .REDIRECT_TARGET(target), .ID_HOLD(id_hold),
        .ID_VALID(id_valid), .ID_PC(id_pc), .ID_INSTRUCTION(id_instr)
`ifdef FETCH_PERF_CNT_EN
        , .PERF_FETCHED(perf_fetched), .PERF_DISCARDED(perf_discarded), .PERF_STARVED(perf_starved)
`endif
    );

    fetch_unit #(.XLEN(XLEN), .FETCH_QUEUE_DEPTH(DEPTH), .RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
        .CLK(CLK), .RESET(RESET),
        .INSTR_MEM_READ(mem_read2), .INSTR_MEM_ADDR(mem_addr2),
        .INSTR_MEM_READ_DATA(mem_data2), .INSTR_MEM_BUSYWAIT(zero_bit),
        .REDIRECT(zero_bit), .REDIRECT_TARGET(zero_word), .ID_HOLD(zero_bit),
        .ID_VALID(id_valid2), .ID_PC(id_pc2), .ID_INSTRUCTION(id_instr2)
`ifdef FETCH_PERF_CNT_EN
        , .PERF_FETCHED(perf_fetched2), .PERF_DISCARDED(perf_discarded2), .PERF_STARVED(perf_starved2)
`endif
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue of {pc, instr}; a flag marks a request being thrown away.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_last_pc, m_last_instr, m_hold_addr;
    bit          m_dropping;
    logic [31:0] m_fetched, m_discarded, m_starved;

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0; m_last_pc = 32'h0; m_last_instr = 32'h0; m_hold_addr = 32'h0;
        m_dropping = 1'b0;
        m_fetched = 0; m_discarded = 0; m_starved = 0;
    endtask

    // Values sampled mid-cycle by the last step.
    bit          s_valid, s_read, s2_valid;
    logic [31:0] s_pc, s_instr, s_addr, s2_pc, s2_instr, s_pd;

    task automatic step(input bit rst, input bit hold, input bit bsy, input bit redir, input logic [31:0] tgt);
        bit          m_read, m_valid, done;
        logic [31:0] m_addr, e_pc, e_instr;
        ent_t        e;
        @(negedge CLK);
        RESET = rst; id_hold = hold; busy = bsy; redirect = redir; target = tgt;
        if (rst) model_reset();
        #1;
        s_valid = id_valid; s_read = mem_read; s_pc = id_pc; s_instr = id_instr; s_addr = mem_addr;
        s2_valid = id_valid2; s2_pc = id_pc2; s2_instr = id_instr2;
        m_valid = (mq.size() > 0);
        m_read  = !rst && (m_dropping || mq.size() < DEPTH);
        m_addr  = m_dropping ? m_hold_addr : m_pc;
        e_pc    = m_valid ? mq[0].pc : m_last_pc;
        e_instr = m_valid ? mq[0].instr : m_last_instr;
        check("id_valid", {31'b0, s_valid}, {31'b0, m_valid});
        check("id_pc", s_pc, e_pc);
        check("id_instr", s_instr, e_instr);
        check("mem_read", {31'b0, s_read}, {31'b0, m_read});
        if (m_read) check("mem_addr", s_addr, m_addr);
`ifdef FETCH_PERF_CNT_EN
        s_pd = perf_discarded;
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_discarded", perf_discarded, m_discarded);
        check("perf_starved", perf_starved, m_starved);
`else
        s_pd = 32'h0;
`endif
        @(posedge CLK);
        if (!rst) begin
            done = m_read && !bsy;
            if (mq.size() == 0) m_starved++;
            if (redir) begin
                m_discarded += mq.size() + ((m_dropping && done) ? 1 : 0);
                mq.delete();
                if (m_read && bsy) begin
                    if (!m_dropping) m_hold_addr = m_pc;
                    m_dropping = 1'b1;
                end else begin
                    m_dropping = 1'b0;
                end
                m_pc = tgt & ~32'h3;
            end else if (m_dropping) begin
                if (done) begin
                    m_dropping = 1'b0;
                    m_discarded++;
                end
            end else begin
                if (mq.size() > 0 && !hold) begin
                    e = mq.pop_front();
                    m_last_pc = e.pc;
                    m_last_instr = e.instr;
                end
                if (done) begin
                    e.pc = m_pc;
                    e.instr = m_pc ^ xor_key;
                    mq.push_back(e);
                    m_fetched++;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    typedef struct {
        bit          rst, hold;
        bit          exp_valid, exp_read;
        logic [31:0] exp_pc, exp_addr;
    } vec_t;

    function automatic vec_t mk(bit rst, bit hold, bit v, logic [31:0] pc, bit rd, logic [31:0] addr);
        vec_t t;
        t.rst = rst; t.hold = hold; t.exp_valid = v; t.exp_pc = pc; t.exp_read = rd; t.exp_addr = addr;
        return t;
    endfunction

    vec_t tab[$];

    initial begin
        logic [31:0] wrap_exp [5];
        logic [31:0] pd_before;

        id_hold = 0; busy = 0; redirect = 0; target = 0;
        model_reset();

        // Zero-wait start-up, then a hold that fills the FIFO and its release.
        tab.push_back(mk(1, 0, 0, 32'h00, 0, 32'h00));
        tab.push_back(mk(0, 0, 0, 32'h00, 1, 32'h00));
        tab.push_back(mk(0, 0, 1, 32'h00, 1, 32'h04));
        tab.push_back(mk(0, 0, 1, 32'h04, 1, 32'h08));
        tab.push_back(mk(0, 0, 1, 32'h08, 1, 32'h0C));
        tab.push_back(mk(0, 0, 1, 32'h0C, 1, 32'h10));
        tab.push_back(mk(1, 0, 0, 32'h00, 0, 32'h00));
        tab.push_back(mk(0, 1, 0, 32'h00, 1, 32'h00));
        tab.push_back(mk(0, 1, 1, 32'h00, 1, 32'h04));
        tab.push_back(mk(0, 1, 1, 32'h00, 1, 32'h08));
        tab.push_back(mk(0, 1, 1, 32'h00, 1, 32'h0C));
        for (int i = 0; i < 6; i++) tab.push_back(mk(0, 1, 1, 32'h00, 0, 32'h10));
        tab.push_back(mk(0, 0, 1, 32'h00, 0, 32'h10));
        tab.push_back(mk(0, 0, 1, 32'h04, 1, 32'h10));
        tab.push_back(mk(0, 0, 1, 32'h08, 1, 32'h14));
        tab.push_back(mk(0, 0, 1, 32'h0C, 1, 32'h18));
        tab.push_back(mk(0, 0, 1, 32'h10, 1, 32'h1C));

        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].rst, tab[i].hold, 0, 0, 32'h0);
            check($sformatf("tab%0d_valid", i), {31'b0, s_valid}, {31'b0, tab[i].exp_valid});
            check($sformatf("tab%0d_pc", i), s_pc, tab[i].exp_pc);
            check($sformatf("tab%0d_instr", i), s_instr, tab[i].exp_pc);
            check($sformatf("tab%0d_read", i), {31'b0, s_read}, {31'b0, tab[i].exp_read});
            if (tab[i].exp_read) check($sformatf("tab%0d_addr", i), s_addr, tab[i].exp_addr);
        end

        // PC wrap from a high reset vector.
        wrap_exp[0] = 32'h0; wrap_exp[1] = 32'hFFFF_FFF8; wrap_exp[2] = 32'hFFFF_FFFC;
        wrap_exp[3] = 32'h0000_0000; wrap_exp[4] = 32'h0000_0004;
        step(1, 0, 0, 0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 32'h0);
            check($sformatf("wrap%0d_valid", k), {31'b0, s2_valid}, (k == 0) ? 32'h0 : 32'h1);
            if (k > 0) begin
                check($sformatf("wrap%0d_pc", k), s2_pc, wrap_exp[k]);
                check($sformatf("wrap%0d_instr", k), s2_instr, wrap_exp[k]);
            end
        end

        // Redirect during a busy transfer: the abandoned word at 8 must never reach ID.
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0);
        check("busy_addr0", s_addr, 32'h8);
        step(0, 0, 1, 1, 32'h100);
        step(0, 0, 1, 0, 32'h0);
        check("discard_read", {31'b0, s_read}, 32'h1);
        check("discard_addr", s_addr, 32'h8);
        step(0, 0, 0, 0, 32'h0);
        check("discard_done_addr", s_addr, 32'h8);
        step(0, 0, 0, 0, 32'h0);
        check("target_addr", s_addr, 32'h100);
        check("target_valid", {31'b0, s_valid}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("target_first_valid", {31'b0, s_valid}, 32'h1);
        check("target_first_pc", s_pc, 32'h100);

        // Redirect with a misaligned target while three entries are held.
        step(1, 0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 1, 32'h203);
        check("flush_pre_valid", {31'b0, s_valid}, 32'h1);
        pd_before = s_pd;
        step(0, 1, 0, 0, 32'h0);
        check("flush_valid", {31'b0, s_valid}, 32'h0);
        check("flush_addr", s_addr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
        check("flush_perf_disc", s_pd - pd_before, 32'd3);
`endif

        // Asynchronous reset in the middle of a busy transfer with three entries queued.
        step(1, 0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        check("pre_reset_read", {31'b0, s_read}, 32'h1);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        check("async_valid", {31'b0, id_valid}, 32'h0);
        check("async_read", {31'b0, mem_read}, 32'h0);
        check("async_pc", id_pc, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("restart_addr", s_addr, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("restart_pc", s_pc, 32'h0);

        // Random traffic against the model, with data distinct from the address.
        xor_key = 32'h5A3C_0000 | ($urandom() & 32'h0000_FFF0);
        step(1, 0, 0, 0, 32'h0);
        for (int k = 0; k < 1500; k++) begin
            step(0, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 8, $urandom());
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
